// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider controller.
//   DIV_WIDTH   : default operand width
//   div_state_e : sequencer state encoding (IDLE=0, RUN=1, DONE=2)
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// Combinational step of the divider: unsigned R>=B compare and R-B subtract.
// Ports:
//   R    in  WIDTH  current remainder
//   B    in  WIDTH  latched divisor
//   Ge   out 1      R >= B (unsigned)
//   Diff out WIDTH  R - B (only meaningful when Ge is high)
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] B,
  output logic             Ge,
  output logic [WIDTH-1:0] Diff
);

  assign Ge   = (R >= B);
  assign Diff = R - B;

endmodule

// File: rtl/div_sequencer.sv
// Start/Busy/Done controller for the repeated-subtraction divider. Owns the
// latched divisor, remainder register and quotient counter; performs one
// compare/subtract per clock.
// Optional feature: define DIV_TIMEOUT_EN to cap the iteration count at
// MAX_ITER (otherwise Timeout is tied low and no cap logic exists).
// Ports:
//   Clk     in  1        clock, rising edge
//   Reset   in  1        synchronous, active-low reset
//   Start   in  1        request, sampled only in IDLE
//   A, B    in  WIDTH    dividend / divisor, captured on the accepting edge
//   Busy    out 1        high in RUN
//   Done    out 1        one-cycle result-valid pulse
//   DivZero out 1        last op had B==0; held until next accept
//   Timeout out 1        last op hit the cap; held until next accept
//   Out     out 2*WIDTH  {quotient, remainder}
//
// state | meaning
// IDLE  | waiting for Start; result registers hold last result
// RUN   | one subtract per edge while R >= B
// DONE  | single-cycle Done pulse, then back to IDLE
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH    = DIV_WIDTH,
  parameter int MAX_ITER = 65535
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic               DivZero,
  output logic               Timeout,
  output logic [2*WIDTH-1:0] Out
);

  div_state_e state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dz_q, dz_d;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic             cap_hit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .R    (r_q),
    .B    (b_q),
    .Ge   (ge),
    .Diff (diff)
  );

`ifdef DIV_TIMEOUT_EN
  localparam logic [WIDTH-1:0] CAP = WIDTH'(MAX_ITER);
  logic to_q, to_d;
  assign cap_hit = (q_q == CAP);
  assign Timeout = to_q;
`else
  logic unused_cap;
  assign unused_cap = |MAX_ITER;
  assign cap_hit    = 1'b0;
  assign Timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    r_d     = r_q;
    q_d     = q_q;
    dz_d    = dz_q;
`ifdef DIV_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          b_d  = B;
          r_d  = A;
          q_d  = '0;
          dz_d = 1'b0;
`ifdef DIV_TIMEOUT_EN
          to_d = 1'b0;
`endif
          if (B == '0) begin
            // Divide by zero reports an all-ones quotient and the dividend.
            q_d     = '1;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (ge && cap_hit) begin
          // Cap reached with work left: stop without subtracting.
          state_d = ST_DONE;
`ifdef DIV_TIMEOUT_EN
          to_d    = 1'b1;
`endif
        end else if (ge) begin
          r_d = diff;
          q_d = q_q + 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dz_q    <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dz_q    <= dz_d;
`ifdef DIV_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign Busy    = (state_q == ST_RUN);
  assign Done    = (state_q == ST_DONE);
  assign DivZero = dz_q;
  assign Out     = {q_q, r_q};

endmodule
